// File: rtl/lisnoc16_sysctrl_sched_pkg.sv
// rtl/lisnoc16_sysctrl_sched_pkg.sv - shared flit, command and state definitions for the sysctrl scheduler
// Purpose: LISNoC16 flit field layout, control packet class, system-control
//          command bit positions, scheduler state encoding and a flit builder.
// Ports:   none (package).
package lisnoc16_sysctrl_sched_pkg;

  // LISNoC16 flit layout: {type[17:16], dest[15:12], class[11:9], payload[8:0]}
  localparam int FLIT16_WIDTH        = 18;
  localparam int FLIT16_TYPE_W       = 2;
  localparam int FLIT16_DEST_W       = 4;
  localparam int PACKET16_CLASS_W    = 3;

  localparam logic [FLIT16_TYPE_W-1:0] FLIT16_TYPE_PAYLOAD = 2'b00;
  localparam logic [FLIT16_TYPE_W-1:0] FLIT16_TYPE_HEADER  = 2'b01;
  localparam logic [FLIT16_TYPE_W-1:0] FLIT16_TYPE_LAST    = 2'b10;
  localparam logic [FLIT16_TYPE_W-1:0] FLIT16_TYPE_SINGLE  = 2'b11;

  localparam logic [PACKET16_CLASS_W-1:0] PACKET16_CLASS_CONTROL = 3'd7;

  // System-control command bitmask positions
  localparam int SYSCTRL_CMD_W           = 8;
  localparam int SYSCTRL_RESET_BIT       = 0;
  localparam int SYSCTRL_CLK_GATE_BIT    = 1;
  localparam int SYSCTRL_CPU_START_BIT   = 2;
  localparam int SYSCTRL_CPU_STOP_BIT    = 3;
  localparam int SYSCTRL_MON_START_BIT   = 4;
  localparam int SYSCTRL_MON_STOP_BIT    = 5;

  typedef logic [FLIT16_WIDTH-1:0] flit16_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_e;

  // Fields that identify an ACK: type, class and the echoed command byte.
  // The echo's destination field and payload bit 8 are don't-care.
  localparam flit16_t ACK_MASK = {{FLIT16_TYPE_W{1'b1}}, {FLIT16_DEST_W{1'b0}},
                                  {PACKET16_CLASS_W{1'b1}}, 1'b0, {SYSCTRL_CMD_W{1'b1}}};

  function automatic flit16_t make_ctrl_flit(input logic [FLIT16_DEST_W-1:0] dest,
                                             input logic [SYSCTRL_CMD_W-1:0] cmd);
    return {FLIT16_TYPE_SINGLE, dest, PACKET16_CLASS_CONTROL, 1'b0, cmd};
  endfunction

endpackage

// File: rtl/lisnoc16_sysctrl_sched_if.sv
// rtl/lisnoc16_sysctrl_sched_if.sv - requester and NoC port bundle of the sysctrl scheduler
// Purpose: groups the requester handshake, completion report and NoC tx/rx ports.
// Ports:   req_valid/req_cmd/req_ready, done_valid/done_err,
//          out_flit/out_valid/out_ready (tx), in_flit/in_valid/in_ready (rx).
//          master = requesters plus NoC router side, slave = scheduler side.
interface lisnoc16_sysctrl_sched_if
  import lisnoc16_sysctrl_sched_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]               req_valid;
  logic [N_REQ*SYSCTRL_CMD_W-1:0] req_cmd;
  logic [N_REQ-1:0]               req_ready;
  logic [N_REQ-1:0]               done_valid;
  logic                           done_err;
  flit16_t                        out_flit;
  logic                           out_valid;
  logic                           out_ready;
  flit16_t                        in_flit;
  logic                           in_valid;
  logic                           in_ready;

  modport master (
    output req_valid, req_cmd, out_ready, in_flit, in_valid,
    input  req_ready, done_valid, done_err, out_flit, out_valid, in_ready
  );

  modport slave (
    input  req_valid, req_cmd, out_ready, in_flit, in_valid,
    output req_ready, done_valid, done_err, out_flit, out_valid, in_ready
  );
endinterface

// File: rtl/lisnoc16_rr_arbiter.sv
// rtl/lisnoc16_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first asserted request at or after ptr, wrapping at N_REQ.
// Ports:   req (requests), ptr (highest-priority index),
//          grant (one-hot, zero when no request), grant_idx (index of grant).
module lisnoc16_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);
  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0] idx;

  // Scan from the farthest offset back to ptr so the nearest hit is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/lisnoc16_sysctrl_sched.sv
// rtl/lisnoc16_sysctrl_sched.sv - round-robin system-control command scheduler on one NoC port
// Purpose: grants one requester at a time, sends its command as a single CONTROL
//          flit to the sysctrl tile, waits for the echoed ACK with timeout and
//          retry, then pulses done_valid/done_err back to that requester.
// Ports:   clk, rst (async, active high), bus (slave modport: requester
//          handshake, completion report, NoC tx and rx ports).
module lisnoc16_sysctrl_sched
  import lisnoc16_sysctrl_sched_pkg::*;
#(
  parameter int                       N_REQ        = 4,
  parameter logic [FLIT16_DEST_W-1:0] sysctrl_dest = '0,
  parameter int                       TIMEOUT      = 255,
  parameter int                       MAX_RETRY    = 3
) (
  input logic                     clk,
  input logic                     rst,
  lisnoc16_sysctrl_sched_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  sched_state_e             state_q, state_d;
  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]            id_q, id_d;
  logic [SYSCTRL_CMD_W-1:0] cmd_q, cmd_d;
  logic [RW-1:0]            retry_cnt_q, retry_cnt_d;
  logic [15:0]              timer_q, timer_d;
  logic                     out_valid_q, out_valid_d;
  flit16_t                  out_flit_q, out_flit_d;
  logic [N_REQ-1:0]         done_valid_q, done_valid_d;
  logic                     done_err_q, done_err_d;

  logic [N_REQ-1:0]         grant;
  logic [PW-1:0]            grant_idx;
  logic [SYSCTRL_CMD_W-1:0] granted_cmd;
  logic                     ack_hit;

  lisnoc16_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign granted_cmd = bus.req_cmd[int'(grant_idx)*SYSCTRL_CMD_W +: SYSCTRL_CMD_W];
  assign ack_hit     = bus.in_valid &&
                       ((bus.in_flit & ACK_MASK) == (make_ctrl_flit('0, cmd_q) & ACK_MASK));

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    cmd_d        = cmd_q;
    retry_cnt_d  = retry_cnt_q;
    timer_d      = timer_q;
    out_valid_d  = out_valid_q;
    out_flit_d   = out_flit_q;
    done_valid_d = '0;
    done_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          cmd_d       = granted_cmd;
          id_d        = grant_idx;
          rr_ptr_d    = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
          retry_cnt_d = '0;
          out_valid_d = 1'b1;
          out_flit_d  = make_ctrl_flit(sysctrl_dest, granted_cmd);
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          timer_d     = 16'(TIMEOUT);
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        timer_d = timer_q - 16'd1;
        // An ACK in the expiry cycle still counts as success.
        if (ack_hit) begin
          done_valid_d = N_REQ'(1) << id_q;
          state_d      = ST_DONE;
        end else if (timer_q == 16'd0) begin
          if (retry_cnt_q < RW'(MAX_RETRY)) begin
            retry_cnt_d = retry_cnt_q + RW'(1);
            out_valid_d = 1'b1;
            state_d     = ST_SEND;
          end else begin
            done_valid_d = N_REQ'(1) << id_q;
            done_err_d   = 1'b1;
            state_d      = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      cmd_q        <= '0;
      retry_cnt_q  <= '0;
      timer_q      <= '0;
      out_valid_q  <= 1'b0;
      out_flit_q   <= '0;
      done_valid_q <= '0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      cmd_q        <= cmd_d;
      retry_cnt_q  <= retry_cnt_d;
      timer_q      <= timer_d;
      out_valid_q  <= out_valid_d;
      out_flit_q   <= out_flit_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
    end
  end

  // Grant is combinational; gating with rst keeps it quiet while reset is held.
  assign bus.req_ready  = (state_q == ST_IDLE && !rst) ? grant : '0;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_flit   = out_flit_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_err   = done_err_q;
  assign bus.in_ready   = 1'b1;
endmodule

// File: tb/tb_lisnoc16_sysctrl_sched.sv
// tb/tb_lisnoc16_sysctrl_sched.sv - self-checking bench for the sysctrl scheduler
module tb_lisnoc16_sysctrl_sched;
  import lisnoc16_sysctrl_sched_pkg::*;

  localparam int N  = 4;
  localparam int TO = 10;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lisnoc16_sysctrl_sched_if #(.N_REQ(N)) bus ();

  lisnoc16_sysctrl_sched #(
    .N_REQ(N), .sysctrl_dest(4'd0), .TIMEOUT(TO), .MAX_RETRY(MR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int      exp_grant_q[$];
  flit16_t exp_flit_q[$];
  int      exp_done_id_q[$];
  logic    exp_done_err_q[$];

  int   mon_id;
  logic mon_err;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic flit16_t ctrl_flit(input logic [7:0] c);
    return {FLIT16_TYPE_SINGLE, 4'd0, PACKET16_CLASS_CONTROL, 1'b0, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input int id, input logic [7:0] c, input int n_flits, input int err);
    exp_grant_q.push_back(id);
    for (int i = 0; i < n_flits; i++) exp_flit_q.push_back(ctrl_flit(c));
    if (err >= 0) begin
      exp_done_id_q.push_back(id);
      exp_done_err_q.push_back(err[0]);
    end
  endtask

  // Scoreboard: every grant, accepted flit and completion must match the next expectation.
  always @(negedge clk) begin
    if (|bus.req_ready) begin
      check("grant_expected", 32'(exp_grant_q.size() != 0), 32'd1);
      if (exp_grant_q.size() != 0) begin
        mon_id = exp_grant_q.pop_front();
        check("grant_onehot", 32'(bus.req_ready), 32'd1 << mon_id);
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      check("flit_expected", 32'(exp_flit_q.size() != 0), 32'd1);
      if (exp_flit_q.size() != 0) check("flit_value", 32'(bus.out_flit), 32'(exp_flit_q.pop_front()));
    end
    if (|bus.done_valid) begin
      check("done_expected", 32'(exp_done_id_q.size() != 0), 32'd1);
      if (exp_done_id_q.size() != 0) begin
        mon_id  = exp_done_id_q.pop_front();
        mon_err = exp_done_err_q.pop_front();
        check("done_id", 32'(bus.done_valid), 32'd1 << mon_id);
        check("done_err", 32'(bus.done_err), 32'(mon_err));
      end
    end
  end

  initial begin
    int g;
    int sends;
    int first;
    int quiet;

    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.out_ready = 1'b0;
    bus.in_flit   = '0;
    bus.in_valid  = 1'b0;
    tick;
    tick;

    // Reset values, with every requester asking while reset is held
    bus.req_valid = '1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_done_valid", 32'(bus.done_valid), 32'd0);
    check("rst_done_err", 32'(bus.done_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_flit", 32'(bus.out_flit), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    tick;

    // Round-robin with all requesters valid and immediate ACKs
    bus.out_ready = 1'b1;
    bus.req_cmd   = 32'h08040201;
    for (int i = 0; i < 5; i++) expect_cmd(i % 4, 8'(1 << (i % 4)), 1, 0);
    bus.req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_grant", 32'(bus.req_ready), 32'd1 << (i % 4));
      tick;
      if (i == 4) bus.req_valid = '0;
      check("rr_send", 32'(bus.out_valid), 32'd1);
      tick;
      bus.in_valid = 1'b1;
      bus.in_flit  = ctrl_flit(8'(1 << (i % 4)));
      tick;
      bus.in_valid = 1'b0;
      check("rr_done", 32'(bus.done_valid), 32'd1 << (i % 4));
      tick;
    end

    // Single request, ACK three cycles after the send cycle
    tick;
    expect_cmd(0, 8'h01, 1, 0);
    bus.req_valid = 4'b0001;
    tick;
    bus.req_valid = '0;
    check("single_out_valid", 32'(bus.out_valid), 32'd1);
    tick;
    tick;
    tick;
    bus.in_valid = 1'b1;
    bus.in_flit  = ctrl_flit(8'h01);
    check("single_no_early_done", 32'(bus.done_valid), 32'd0);
    tick;
    bus.in_valid = 1'b0;
    check("single_done_valid", 32'(bus.done_valid), 32'd1);
    check("single_done_err", 32'(bus.done_err), 32'd0);
    tick;

    // Timeout and retry exhaustion, no ACK at all
    tick;
    bus.req_cmd[15:8] = 8'h10;
    expect_cmd(1, 8'h10, MR + 1, 1);
    bus.req_valid = 4'b0010;
    sends = 0;
    first = -1;
    for (int k = 1; k <= 38; k++) begin
      tick;
      if (k == 1) bus.req_valid = '0;
      if (bus.out_valid && bus.out_ready) sends++;
      if ((|bus.done_valid) && first < 0) first = k;
    end
    check("timeout_sends", 32'(sends), 32'(MR + 1));
    check("timeout_done_cycle", 32'(first), 32'((MR + 1) * (TO + 2) + 1));

    // Mismatching echo is dropped, matching echo completes
    tick;
    bus.req_cmd[23:16] = 8'h01;
    expect_cmd(2, 8'h01, 1, 0);
    bus.req_valid = 4'b0100;
    tick;
    bus.req_valid = '0;
    tick;
    bus.in_valid = 1'b1;
    bus.in_flit  = ctrl_flit(8'h02);
    tick;
    bus.in_flit = ctrl_flit(8'h01);
    check("wrong_flit_ignored", 32'(bus.done_valid), 32'd0);
    tick;
    bus.in_valid = 1'b0;
    check("wrong_then_ack_done", 32'(bus.done_valid), 32'b0100);
    check("wrong_then_ack_err", 32'(bus.done_err), 32'd0);
    tick;

    // Backpressure holds the flit; ACK lands in the timer==0 cycle
    tick;
    bus.out_ready = 1'b0;
    bus.req_cmd[31:24] = 8'h04;
    expect_cmd(3, 8'h04, 1, 0);
    bus.req_valid = 4'b1000;
    tick;
    bus.req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_flit", 32'(bus.out_flit), 32'(ctrl_flit(8'h04)));
      tick;
    end
    bus.out_ready = 1'b1;
    tick;
    check("bp_accepted", 32'(bus.out_valid), 32'd0);
    repeat (TO) tick;
    bus.in_valid = 1'b1;
    bus.in_flit  = ctrl_flit(8'h04);
    check("edge_no_early_done", 32'(bus.done_valid), 32'd0);
    tick;
    bus.in_valid = 1'b0;
    check("edge_ack_done", 32'(bus.done_valid), 32'b1000);
    check("edge_ack_err", 32'(bus.done_err), 32'd0);
    tick;

    // Reset during WAIT_ACK aborts silently and restarts the pointer
    tick;
    bus.req_cmd[23:16] = 8'h20;
    expect_cmd(2, 8'h20, 1, -1);
    bus.req_valid = 4'b0100;
    tick;
    bus.req_valid = '0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_done_valid", 32'(bus.done_valid), 32'd0);
    check("midrst_out_flit", 32'(bus.out_flit), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    tick;
    tick;
    rst = 1'b0;
    quiet = 0;
    repeat (15) begin
      tick;
      if (|bus.done_valid) quiet++;
    end
    check("midrst_no_done", 32'(quiet), 32'd0);
    expect_cmd(0, 8'h01, 1, 0);
    bus.req_valid = 4'hF;
    #1;
    check("post_rst_grant", 32'(bus.req_ready), 32'd1);
    tick;
    bus.req_valid = '0;
    tick;
    bus.in_valid = 1'b1;
    bus.in_flit  = ctrl_flit(8'h01);
    tick;
    bus.in_valid = 1'b0;
    check("post_rst_done", 32'(bus.done_valid), 32'd1);
    tick;
    tick;

    check("grant_q_drained", 32'(exp_grant_q.size()), 32'd0);
    check("flit_q_drained", 32'(exp_flit_q.size()), 32'd0);
    check("done_q_drained", 32'(exp_done_id_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
